// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters:
//   port 0 - main execute datapath
//   port 1 - branch/address unit
// A round-robin arbiter picks one requester per cycle. It drives the ALU
// operands and opcode from that requester. The ALU result is captured into a
// single registered response slot, tagged with the requester id.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid / reqN_ready       request handshake, N = 0, 1
//   reqN_a, reqN_b, reqN_opc      request payload
//   alu_a, alu_b, alu_opc         operands/opcode to the ALU
//   alu_res                       combinational result from the ALU
//   rsp_valid / rsp_ready         response handshake
//   rsp_id, rsp_data, rsp_zero    response payload (all registered)
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int DATA_W = 16,
  parameter int OPC_W  = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OPC_W-1:0]  req0_opc,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OPC_W-1:0]  req1_opc,

  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OPC_W-1:0]  alu_opc,
  input  logic [DATA_W-1:0] alu_res,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero
);

  logic              rsp_valid_reg;
  logic              rsp_id_reg;
  logic [DATA_W-1:0] rsp_data_reg;
  logic              rsp_zero_reg;
  logic              rr_ptr_reg;   // port favoured on the next conflict

  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic       can_accept;
  logic       grant_any;
  logic       grant_id;
  logic       accept;

  assign req_valid = {req1_valid, req0_valid};

  // The slot can take a new result when it is empty or being drained now.
  // This lets the slot drain and refill in the same cycle.
  assign can_accept = ~rsp_valid_reg | rsp_ready;

  // If only one port is valid, that port wins. If both are valid, the
  // round-robin pointer decides. If neither is valid, grant_id is 0.
  assign grant_any = |req_valid;
  assign grant_id  = (&req_valid) ? rr_ptr_reg : req_valid[1];
  assign accept    = grant_any & can_accept & ~rst;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready[gi] = accept & (grant_id == 1'(gi));
    end
  endgenerate

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];

  // With no grant, the mux falls back to port 0. Nothing is captured in that
  // case because no ready is high.
  always_comb begin
    alu_a   = req0_a;
    alu_b   = req0_b;
    alu_opc = req0_opc;
    if (grant_any && grant_id) begin
      alu_a   = req1_a;
      alu_b   = req1_b;
      alu_opc = req1_opc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_zero_reg  <= 1'b0;
      rr_ptr_reg    <= 1'b0;
    end else if (accept) begin
      rsp_valid_reg <= 1'b1;
      rsp_id_reg    <= grant_id;
      rsp_data_reg  <= alu_res;
      rsp_zero_reg  <= (alu_res == '0);
      // The port that just lost gets priority on the next conflict.
      rr_ptr_reg    <= ~grant_id;
    end else if (rsp_ready) begin
      // Drain with no refill. The payload keeps its last value.
      rsp_valid_reg <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_zero  = rsp_zero_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Self-checking bench for alu_arbiter. It provides a behavioural ALU. It also
// keeps a transaction-level model of the response slot and the round-robin
// preference. Scenario tasks are called in sequence and compare inline.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
  localparam int DW = 16;
  localparam int OW = 4;

  logic          clk;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OW-1:0] req0_opc, req1_opc;
  logic [DW-1:0] alu_a, alu_b, alu_res;
  logic [OW-1:0] alu_opc;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [DW-1:0] rsp_data;

  int errors = 0;
  int checks = 0;

  alu_arbiter #(.DATA_W(DW), .OPC_W(OW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_opc(req0_opc),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_opc(req1_opc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opc(alu_opc), .alu_res(alu_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU.
  function automatic logic [DW-1:0] alu_ref(input logic [DW-1:0] a, b, input logic [OW-1:0] opc);
    case (opc)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      4'd3:    return a | b;
      4'd4:    return a & b;
      4'd5:    return a << b[3:0];
      4'd9:    return (a == b) ? 16'd1 : 16'd0;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_res = alu_ref(alu_a, alu_b, alu_opc);

  // Reference model state.
  bit            m_valid, m_id, m_zero, m_ptr;
  logic [DW-1:0] m_data;
  // Expected and observed values for the cycle just applied.
  bit            e_r0, e_r1, o_r0, o_r1;
  logic [DW-1:0] e_alu_a, e_alu_b, o_alu_a, o_alu_b;
  logic [OW-1:0] e_alu_opc, o_alu_opc;

  // Drive one cycle of stimulus. The task samples the combinational outputs
  // before the edge, advances the model across the edge, and returns 1 ns
  // after the edge.
  task automatic apply(input bit v0, input logic [DW-1:0] a0, b0, input logic [OW-1:0] o0,
                       input bit v1, input logic [DW-1:0] a1, b1, input logic [OW-1:0] o1,
                       input bit rr, input bit r);
    bit can, any, win;
    @(negedge clk);
    rst = r; rsp_ready = rr;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_opc = o0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_opc = o1;
    #1;
    can  = !m_valid || rr;
    any  = v0 || v1;
    win  = (v0 && v1) ? m_ptr : v1;
    e_r0 = !r && can && any && !win;
    e_r1 = !r && can && any && win;
    e_alu_a   = (any && win) ? a1 : a0;
    e_alu_b   = (any && win) ? b1 : b0;
    e_alu_opc = (any && win) ? o1 : o0;
    o_r0 = req0_ready; o_r1 = req1_ready;
    o_alu_a = alu_a; o_alu_b = alu_b; o_alu_opc = alu_opc;
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_id = 0; m_data = '0; m_zero = 0; m_ptr = 0;
    end else if (e_r0 || e_r1) begin
      m_data  = e_r1 ? alu_ref(a1, b1, o1) : alu_ref(a0, b0, o0);
      m_zero  = (m_data == 0);
      m_id    = e_r1;
      m_valid = 1;
      m_ptr   = !e_r1;
    end else if (rr) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1, 16'd3, 16'd4, 4'd0, 1, 16'd5, 16'd6, 4'd1, 1, 1);
      checks++;
      if (o_r0 !== 1'b0 || o_r1 !== 1'b0) begin
        errors++; $display("FAIL reset_ready: got %b%b want 00", o_r1, o_r0);
      end
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_zero} !== 3'b000 || rsp_data !== 16'd0) begin
      errors++; $display("FAIL reset_state: got v=%b id=%b z=%b d=%0d want 0 0 0 0",
                         rsp_valid, rsp_id, rsp_zero, rsp_data);
    end
    $display("test_reset: rsp_valid=%b rsp_data=%0d", rsp_valid, rsp_data);
  endtask

  task automatic test_single();
    apply(1, 16'd8, 16'd2, 4'd0, 0, 16'd0, 16'd0, 4'd0, 1, 0);
    checks++;
    if (o_r0 !== 1'b1 || o_r1 !== 1'b0) begin
      errors++; $display("FAIL single_ready: got r1r0=%b%b want 01", o_r1, o_r0);
    end
    checks++;
    if (o_alu_a !== 16'd8 || o_alu_b !== 16'd2 || o_alu_opc !== 4'd0) begin
      errors++; $display("FAIL single_alu_drive: got %0d %0d %0d want 8 2 0", o_alu_a, o_alu_b, o_alu_opc);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 16'd10 || rsp_zero !== 1'b0) begin
      errors++; $display("FAIL single_rsp: got v=%b id=%b d=%0d z=%b want 1 0 10 0",
                         rsp_valid, rsp_id, rsp_data, rsp_zero);
    end
    $display("test_single: rsp_id=%b rsp_data=%0d", rsp_id, rsp_data);
    apply(0, 16'd0, 16'd0, 4'd0, 0, 16'd0, 16'd0, 4'd0, 1, 0);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 16'd10) begin
      errors++; $display("FAIL single_drain: got v=%b d=%0d want 0 10", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_conflict();
    logic [DW-1:0] want_d;
    apply(0, 16'd0, 16'd0, 4'd0, 0, 16'd0, 16'd0, 4'd0, 1, 1);
    for (int k = 0; k < 6; k++) begin
      apply(1, 16'd8, 16'd2, 4'd1, 1, 16'd8, 16'd2, 4'd5, 1, 0);
      want_d = (k % 2 == 0) ? 16'd6 : 16'd32;
      checks++;
      if (o_r0 !== !k[0] || o_r1 !== k[0]) begin
        errors++; $display("FAIL conflict_ready[%0d]: got r1r0=%b%b want %b%b", k, o_r1, o_r0, k[0], !k[0]);
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== k[0] || rsp_data !== want_d) begin
        errors++; $display("FAIL conflict_rsp[%0d]: got v=%b id=%b d=%0d want 1 %b %0d",
                           k, rsp_valid, rsp_id, rsp_data, k[0], want_d);
      end
      $display("test_conflict[%0d]: rsp_id=%b rsp_data=%0d", k, rsp_id, rsp_data);
    end
  endtask

  task automatic test_zero();
    apply(0, 16'd0, 16'd0, 4'd0, 1, 16'd8, 16'd2, 4'd4, 1, 0);
    checks++;
    if (rsp_data !== 16'd0 || rsp_zero !== 1'b1 || rsp_id !== 1'b1 || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL zero_and: got d=%0d z=%b id=%b v=%b want 0 1 1 1", rsp_data, rsp_zero, rsp_id, rsp_valid);
    end
    $display("test_zero and: rsp_data=%0d rsp_zero=%b", rsp_data, rsp_zero);
    apply(0, 16'd0, 16'd0, 4'd0, 1, 16'd8, 16'd2, 4'd3, 1, 0);
    checks++;
    if (rsp_data !== 16'd10 || rsp_zero !== 1'b0 || rsp_id !== 1'b1) begin
      errors++; $display("FAIL zero_or: got d=%0d z=%b id=%b want 10 0 1", rsp_data, rsp_zero, rsp_id);
    end
    $display("test_zero or: rsp_data=%0d rsp_zero=%b", rsp_data, rsp_zero);
  endtask

  task automatic test_backpressure();
    apply(1, 16'd8, 16'd2, 4'd0, 0, 16'd0, 16'd0, 4'd0, 1, 0);  // fill slot with 10 from port 0
    for (int k = 0; k < 5; k++) begin
      apply(1, 16'd3, 16'd3, 4'd0, 1, 16'd8, 16'd2, 4'd5, 0, 0);
      checks++;
      if (o_r0 !== 1'b0 || o_r1 !== 1'b0) begin
        errors++; $display("FAIL bp_ready[%0d]: got r1r0=%b%b want 00", k, o_r1, o_r0);
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'd10 || rsp_id !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%b d=%0d id=%b want 1 10 0", k, rsp_valid, rsp_data, rsp_id);
      end
      $display("test_backpressure hold[%0d]: rsp_data=%0d", k, rsp_data);
    end
    // Port 0 won last, so port 1 takes this conflict once the slot drains.
    apply(1, 16'd3, 16'd3, 4'd0, 1, 16'd8, 16'd2, 4'd5, 1, 0);
    checks++;
    if (o_r0 !== 1'b0 || o_r1 !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: got r1r0=%b%b want 10", o_r1, o_r0);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'd32 || rsp_id !== 1'b1) begin
      errors++; $display("FAIL bp_release_rsp: got v=%b d=%0d id=%b want 1 32 1", rsp_valid, rsp_data, rsp_id);
    end
    $display("test_backpressure release: rsp_id=%b rsp_data=%0d", rsp_id, rsp_data);
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 10; i++) begin
      apply(1, 16'(i), 16'd1, 4'd0, 0, 16'd0, 16'd0, 4'd0, 1, 0);
      checks++;
      if (o_r0 !== 1'b1) begin
        errors++; $display("FAIL stream_ready[%0d]: got %b want 1", i, o_r0);
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 16'(i + 1)) begin
        errors++; $display("FAIL stream_rsp[%0d]: got v=%b id=%b d=%0d want 1 0 %0d", i, rsp_valid, rsp_id, rsp_data, i + 1);
      end
      $display("test_stream[%0d]: rsp_data=%0d", i, rsp_data);
    end
  endtask

  task automatic test_reset_mid();
    apply(1, 16'd3, 16'd4, 4'd0, 0, 16'd0, 16'd0, 4'd0, 1, 0);   // port 0 wins, so port 1 is now favoured
    apply(0, 16'd0, 16'd0, 4'd0, 0, 16'd0, 16'd0, 4'd0, 0, 0);   // hold the slot full
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'd7) begin
      errors++; $display("FAIL mid_fill: got v=%b d=%0d want 1 7", rsp_valid, rsp_data);
    end
    apply(1, 16'd1, 16'd1, 4'd0, 1, 16'd2, 16'd2, 4'd0, 0, 1);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 16'd0 || o_r0 !== 1'b0 || o_r1 !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got v=%b d=%0d r1r0=%b%b want 0 0 00", rsp_valid, rsp_data, o_r1, o_r0);
    end
    apply(1, 16'd1, 16'd1, 4'd0, 1, 16'd2, 16'd2, 4'd0, 1, 0);
    checks++;
    if (o_r0 !== 1'b1 || o_r1 !== 1'b0 || rsp_id !== 1'b0 || rsp_data !== 16'd2) begin
      errors++; $display("FAIL mid_after: got r1r0=%b%b id=%b d=%0d want 01 0 2", o_r1, o_r0, rsp_id, rsp_data);
    end
    $display("test_reset_mid: rsp_id=%b rsp_data=%0d", rsp_id, rsp_data);
  endtask

  task automatic test_random();
    logic [OW-1:0] opc_tab [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9};
    bit            v0 = 0, v1 = 0, rr, r;
    logic [DW-1:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
    logic [OW-1:0] o0 = 0, o1 = 0;
    int            bad = 0;
    for (int n = 0; n < 400; n++) begin
      // A payload that is still waiting stays stable. Otherwise pick a new one.
      if (!(v0 && !o_r0)) begin
        v0 = ($urandom_range(0, 3) != 0);
        a0 = 16'($urandom); b0 = 16'($urandom_range(0, 20));
        o0 = opc_tab[$urandom_range(0, 6)];
      end
      if (!(v1 && !o_r1)) begin
        v1 = ($urandom_range(0, 3) != 0);
        a1 = 16'($urandom); b1 = 16'($urandom_range(0, 20));
        o1 = opc_tab[$urandom_range(0, 6)];
      end
      if ($urandom_range(0, 4) == 0) a0 = b0;  // produce some zero results
      rr = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 60) == 0);
      apply(v0, a0, b0, o0, v1, a1, b1, o1, rr, r);
      checks++;
      if (o_r0 !== e_r0 || o_r1 !== e_r1 || o_alu_a !== e_alu_a || o_alu_b !== e_alu_b || o_alu_opc !== e_alu_opc) begin
        errors++; bad++;
        $display("FAIL rand_issue[%0d]: got r1r0=%b%b alu=%h,%h,%h want %b%b %h,%h,%h",
                 n, o_r1, o_r0, o_alu_a, o_alu_b, o_alu_opc, e_r1, e_r0, e_alu_a, e_alu_b, e_alu_opc);
      end
      checks++;
      if (rsp_valid !== m_valid || rsp_id !== m_id || rsp_data !== m_data || rsp_zero !== m_zero) begin
        errors++; bad++;
        $display("FAIL rand_rsp[%0d]: got v=%b id=%b d=%h z=%b want %b %b %h %b",
                 n, rsp_valid, rsp_id, rsp_data, rsp_zero, m_valid, m_id, m_data, m_zero);
      end
      if (r) begin
        v0 = 0; v1 = 0;
      end
    end
    $display("test_random: 400 cycles, %0d mismatching cycles", bad);
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_opc = '0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_opc = '0;
    m_valid = 0; m_id = 0; m_data = '0; m_zero = 0; m_ptr = 0;
    o_r0 = 0; o_r1 = 0;
    test_reset();
    test_single();
    test_conflict();
    test_zero();
    test_backpressure();
    test_stream();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational 16-bit ALU between two requesters: port 0 is the main execute datapath and port 1 is the branch/address unit.
- Arbitrates round-robin and drives the ALU operands and opcode from the granted requester.
- Captures the ALU result into a registered response slot, tagged with the requester id, using a valid/ready handshake on every side.
- Sits between the decode/issue logic and the ALU instance.

Parameters:
- DATA_W, 16, operand/result width; must match the ALU.
- OPC_W, 4, opcode width; must match the ALU (0 add, 1 sub, 2 slt, 3 or, 4 and, 5 shl, 9 branch).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  DATA_W  requester 0 operand A.
- req0_b  in  DATA_W  requester 0 operand B.
- req0_opc  in  OPC_W  requester 0 opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_opc: same as port 0, for requester 1.
- alu_a  out  DATA_W  to ALU inpA.
- alu_b  out  DATA_W  to ALU inpB.
- alu_opc  out  OPC_W  to ALU opc.
- alu_res  in  DATA_W  from ALU res (combinational).
- rsp_valid  out  1  response slot full.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester that issued the response.
- rsp_data  out  DATA_W  registered ALU result.
- rsp_zero  out  1  rsp_data == 0 (registered with data).

Behaviour:
- Reset: one clock and one reset only; reset is synchronous and active-high (clk, rst).
  - While rst is high on a rising edge: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_zero=0, rr_ptr=0 (port 0 favoured).
  - req*_ready is 0 while rst is high.
  - An in-flight response is discarded by reset.
- can_accept = !rsp_valid | rsp_ready. The slot drains and refills in the same cycle, giving one op per cycle at full throughput.
- Arbitration (combinational):
  - If only one reqN_valid is high, grant N.
  - If both are high, grant rr_ptr.
  - If neither is high, no grant.
- reqN_ready = can_accept & grant==N & !rst. At most one ready is high per cycle.
- ALU drive:
  - alu_a/alu_b/alu_opc are muxed from the granted port.
  - With no grant, they are driven from port 0 (ready stays 0, so nothing is captured).
  - Opcode values are passed through unmodified; undefined opcodes get no special handling.
- Capture, on the edge where reqN_valid & reqN_ready:
  - rsp_data <= alu_res, rsp_zero <= (alu_res==0), rsp_id <= N, rsp_valid <= 1.
  - rr_ptr <= ~N, so the other port wins the next conflict.
- Latency: one cycle from acceptance to rsp_valid.
- Drain: if rsp_valid & rsp_ready and there is no new acceptance, rsp_valid <= 0 and data holds its last value.
- Backpressure: while rsp_valid & !rsp_ready, rsp_* hold stable, both readys are 0, and rr_ptr is unchanged.
- Requester rules:
  - reqN_valid must not depend on reqN_ready.
  - The payload must stay stable while valid & !ready.
  - The arbiter does not latch requests; withdrawn requests are simply lost.
- rr_ptr updates only on an accepted grant. A single active requester gets back-to-back grants with no bubble.
- Fairness: with both requesters continuously valid and rsp_ready=1, grants alternate 0,1,0,1...
- No combinational path exists from rsp_ready to rsp_data. The path from rsp_ready to reqN_ready is permitted.

Test Plan:
1. Reset then single op: rst 2 cycles; req0 a=8 b=2 opc=0 -> req0_ready=1 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=10, rsp_zero=0.
2. Conflict after reset: both valid, req0 8-2 (opc 1) and req1 8<<2 (opc 5), rsp_ready=1.
   -> Port 0 granted first (rsp_data=6, id 0), then port 1 next cycle (rsp_data=32, id 1).
   -> Then alternation continues.
3. Zero flag: req1 a=8 b=2 opc=4 -> rsp_data=0, rsp_zero=1, rsp_id=1; then opc=3 -> rsp_data=10, rsp_zero=0.
4. Backpressure: fill slot (8+2), hold rsp_ready=0 for 5 cycles with req0 and req1 valid.
   -> Both readys=0, rsp_data stays 10.
   -> Raise rsp_ready: same cycle one ready=1 (per rr_ptr), next cycle new result.
5. Streaming: req0 only, valid every cycle, opc 0 with a=1..10, b=1, rsp_ready=1 -> 10 consecutive responses 2..11, no bubbles, all id 0.
6. Reset mid-operation: rsp_valid=1 with rsp_ready=0; assert rst one cycle.
   -> Next cycle rsp_valid=0, rsp_data=0.
   -> The next conflict is granted to port 0.
